muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO architectural registers for the execute stage.
- Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO with a start/busy/done handshake. The pipeline stalls on busy instead of waiting on combinational multiply or divide.
- Adds an iterative restoring divider, a configurable multiply latency, flush/abort, and a registered divide-by-zero flag.

Parameters:
WIDTH, 32, operand width and width of HI and LO.
MUL_CYCLES, 2, cycles from accepted start to done for multiply (allowed range 1..4).

Ports:
clock  input  1  system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
start  input  1  request; sampled only on a rising edge while busy=0.
op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; other codes are no-ops.
operand_a  input  WIDTH  rs value (dividend / multiplicand / mthi-mtlo source).
operand_b  input  WIDTH  rt value (divisor / multiplier).
flush  input  1  abort the in-flight operation (exception or branch squash).
busy  output  1  operation in flight; the pipeline holds mult/div/mf*/mt* instructions.
done  output  1  one-cycle pulse in the cycle HI/LO take new values.
div_zero  output  1  one-cycle pulse coincident with done for a div/divu whose divisor is 0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; all iteration registers cleared. Reset may arrive mid-operation and always wins.
- States: IDLE, MUL, DIV, FIX. All outputs are registered.
- IDLE + start + op=mthi/mtlo:
  - On the next edge, hi (or lo) = operand_a. The other register is unchanged.
  - done=1 for one cycle; busy stays 0.
- IDLE + start + mult/multu:
  - Latch operands; go to MUL; busy=1.
  - The product is formed over MUL_CYCLES edges (pipelined or counted).
  - On the MUL_CYCLES-th edge after the accept edge: {hi,lo} = full 2*WIDTH product (signed for mult, unsigned for multu); done=1, busy=0; return to IDLE.
- IDLE + start + div/divu with operand_b=0:
  - On the next edge: done=1, div_zero=1, busy=0.
  - hi and lo are unchanged.
- IDLE + start + div/divu with operand_b≠0:
  - Take magnitudes of the operands (div only); record quotient and remainder signs.
  - DIV runs one restoring step per cycle for WIDTH cycles, driven by a step counter 0..WIDTH-1.
  - FIX (1 cycle) applies signs: quotient truncates toward zero; remainder takes the dividend's sign. Then lo=quotient, hi=remainder, done=1, busy=0.
  - Total latency is WIDTH+1 edges after the accept edge; busy=1 throughout.
- Signed overflow case (most-negative value / -1): lo=most-negative value, hi=0; no flag.
- start while busy=1 is ignored; operands are not re-latched. Invalid op codes do nothing and leave busy=0.
- flush=1:
  - At the next edge the FSM returns to IDLE; busy=0, done=0, div_zero=0.
  - hi and lo keep their pre-operation values.
  - flush together with start in IDLE: flush wins and start is dropped.
  - flush in the same cycle as the final (done-producing) edge: flush wins and no writeback occurs.
- Operands are registered at accept; later changes on operand_a/operand_b do not affect the result.
- hi and lo change only on a done edge.

Test Plan:
- Reset mid-divide: start div, 7 / 2, then drop resetn at cycle 10 → immediately hi=0, lo=0, busy=0; after release, IDLE with no done pulse.
- mult with MUL_CYCLES=2: a=0xFFFFFFFE (-2), b=0x00000003 → busy for 2 cycles, done on the 2nd edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA. The same operands with multu give hi=0x00000002, lo=0xFFFFFFFA.
- div signs: a=-7, b=2 → after 33 edges lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100 / 7 → lo=14, hi=2. Also 0x80000000 div 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo, then div 5 / 0 → one cycle later done=1, div_zero=1; hi=0x11, lo=0x22.
- Handshake and flush:
  - start divu with a 2nd start pulse at cycle 5 → 2nd start ignored; result matches the first operands.
  - New divu, flush at cycle 20 → busy=0 on the next edge, no done, hi/lo unchanged.
  - Immediate restart → correct result.
- Operand hold: change operand_a/operand_b every cycle after accepting mult 0x10000 × 0x10000 → hi=1, lo=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake bundle between the pipeline and the multiply/divide unit.
// The pipeline side drives requests; the unit side returns status and HI/LO.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: counted multiply, restoring divider
// with a sign-fix cycle, flush/abort and a registered divide-by-zero pulse.
module muldiv_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic          clock,
  input  logic          resetn,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dz_q, dz_d, busy_q, busy_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, prod;
  logic [WIDTH:0]     rem_shift, diff;
  logic               a_neg, b_neg;

  always_comb begin
    mul_a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of the extended product are correct for both signednesses.
    prod      = mul_a_ext * mul_b_ext;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, b_q};
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    a_neg   = 1'b0;
    b_neg   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            OpMult, OpMultu: begin
              a_d     = bus.operand_a;
              b_d     = bus.operand_b;
              sgn_d   = (bus.op == OpMult);
              cnt_d   = '0;
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              if (bus.operand_b == '0) begin
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                a_neg   = (bus.op == OpDiv) && bus.operand_a[WIDTH-1];
                b_neg   = (bus.op == OpDiv) && bus.operand_b[WIDTH-1];
                quo_d   = a_neg ? -bus.operand_a : bus.operand_a;
                b_d     = b_neg ? -bus.operand_b : bus.operand_b;
                rem_d   = '0;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                cnt_d   = '0;
                state_d = StDiv;
              end
            end
            OpMthi: begin
              hi_d   = bus.operand_a;
              done_d = 1'b1;
            end
            OpMtlo: begin
              lo_d   = bus.operand_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDiv: begin
        // Dividend shifts out of quo_q MSB-first while quotient bits shift in.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
